tmc_uart_rx_fifo: RTL and testbench

- Serial-to-parallel UART receiver (8N1, LSB first) with a show-ahead byte FIFO.
- Feeds the Nios II PIO read path: presents the head byte on rx_char_export and empty status on rx_fifo_empty_export.
- Pops one byte per software-driven rx_fifo_read_export pulse.
- Sits between the board RX pin and the tmc_nios2 system.

---
 rtl/tmc_uart_rx_fifo.sv | 259 +++++++++++++++++++++++++
 tb/tb_tmc_uart_rx_fifo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tmc_uart_rx_fifo.sv
// tmc_uart_rx_fifo: 8N1 UART receiver (LSB first) with a show-ahead byte FIFO.
// The head byte and empty status go to the Nios II PIO read path. Software
// pops one byte per rising edge of rx_fifo_read_export. Sticky overflow and
// framing-error flags are cleared by err_clr.
module tmc_uart_rx_fifo #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       uart_rxd,
  input  logic       rx_fifo_read_export,
  output logic [7:0] rx_char_export,
  output logic       rx_fifo_empty_export,
  output logic       rx_fifo_full,
  output logic       rx_overflow,
  output logic       rx_frame_err,
  input  logic       err_clr
);

  // Tick divider, truncated, with a minimum of one clock per tick
  localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W    = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int CNT_W   = FIFO_AW + 1;

  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE      = DIV_W'(1);
  localparam logic [OS_W-1:0]  OS_LAST      = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_ONE       = OS_W'(1);
  localparam logic [CNT_W-1:0] COUNT_FULL   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] COUNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] COUNT_ONE    = CNT_W'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  logic               rxd_meta_r;
  logic               rxd_sync_r;
  logic [DIV_W-1:0]   div_cnt_r;
  logic               tick_s;
  rx_state_t          state_r;
  logic [OS_W-1:0]    tick_cnt_r;
  logic [2:0]         bit_cnt_r;
  logic [7:0]         shift_r;
  logic               push_r;
  logic               ferr_set_r;
  logic               read_d_r;
  logic               pop_s;
  logic               push_s;
  logic               drop_s;
  logic [CNT_W-1:0]   count_nxt_s;
  logic [FIFO_AW-1:0] wr_ptr_r;
  logic [FIFO_AW-1:0] rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [7:0]         mem_r [FIFO_DEPTH];
  logic [7:0]         char_r;
  logic               empty_r;
  logic               full_r;
  logic               overflow_r;
  logic               frame_err_r;

  // Two-stage synchronizer for the asynchronous RX pin, idling high
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rxd_meta_r <= 1'b1;
      rxd_sync_r <= 1'b1;
    end else begin
      rxd_meta_r <= uart_rxd;
      rxd_sync_r <= rxd_meta_r;
    end
  end

  assign tick_s = (div_cnt_r == DIV_LAST);

  // Oversample tick divider, held at zero while idle so a frame starts phase-aligned
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      div_cnt_r <= '0;
    end else if (state_r == ST_IDLE) begin
      div_cnt_r <= '0;
    end else if (tick_s) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_ONE;
    end
  end

  // Receive FSM: start-bit qualification, mid-bit data sampling, stop check
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_r    <= ST_IDLE;
      tick_cnt_r <= '0;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      push_r     <= 1'b0;
      ferr_set_r <= 1'b0;
    end else begin
      push_r     <= 1'b0;
      ferr_set_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!rxd_sync_r) begin
            state_r    <= ST_START;
            tick_cnt_r <= '0;
          end
        end
        ST_START: begin
          if (tick_s) begin
            if (tick_cnt_r == OS_HALF_LAST) begin
              if (rxd_sync_r) begin
                state_r <= ST_IDLE;
              end else begin
                state_r    <= ST_DATA;
                bit_cnt_r  <= 3'd0;
                tick_cnt_r <= '0;
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + OS_ONE;
            end
          end
        end
        ST_DATA: begin
          if (tick_s) begin
            if (tick_cnt_r == OS_LAST) begin
              tick_cnt_r <= '0;
              shift_r    <= {rxd_sync_r, shift_r[7:1]};
              if (bit_cnt_r == 3'd7) begin
                state_r <= ST_STOP;
              end else begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + OS_ONE;
            end
          end
        end
        ST_STOP: begin
          if (tick_s) begin
            if (tick_cnt_r == OS_LAST) begin
              tick_cnt_r <= '0;
              if (rxd_sync_r) begin
                push_r  <= 1'b1;
                state_r <= ST_IDLE;
              end else begin
                ferr_set_r <= 1'b1;
                state_r    <= ST_BREAK;
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + OS_ONE;
            end
          end
        end
        ST_BREAK: begin
          if (rxd_sync_r) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Registered copy of the read level for rising-edge pop detection
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      read_d_r <= 1'b0;
    end else begin
      read_d_r <= rx_fifo_read_export;
    end
  end

  // A pop frees a slot before the push lands, so a full FIFO still accepts the byte
  assign pop_s  = rx_fifo_read_export & ~read_d_r & (count_r != COUNT_ZERO);
  assign push_s = push_r & ((count_r != COUNT_FULL) | pop_s);
  assign drop_s = push_r & ~push_s;

  // Next occupancy from the accepted push and pop
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + COUNT_ONE;
      2'b01:   count_nxt_s = count_r - COUNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO storage, pointers, occupancy and registered empty/full flags
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= shift_r;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
      empty_r <= (count_nxt_s == COUNT_ZERO);
      full_r  <= (count_nxt_s == COUNT_FULL);
    end
  end

  // Show-ahead head byte, following the read pointer one cycle behind
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      char_r <= 8'h00;
    end else begin
      char_r <= mem_r[rd_ptr_r];
    end
  end

  // Sticky error flags; a clear request overrides a same-cycle set
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      overflow_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else if (err_clr) begin
      overflow_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (ferr_set_r) begin
        frame_err_r <= 1'b1;
      end
    end
  end

  assign rx_char_export       = char_r;
  assign rx_fifo_empty_export = empty_r;
  assign rx_fifo_full         = full_r;
  assign rx_overflow          = overflow_r;
  assign rx_frame_err         = frame_err_r;

endmodule

// File: tb/tb_tmc_uart_rx_fifo.sv
// tb_tmc_uart_rx_fifo: drives 8N1 frames into tmc_uart_rx_fifo at 160 clocks
// per bit. Every byte the FIFO should accept goes into a scoreboard queue.
// Each pop compares the head byte against the front of that queue.
module tb_tmc_uart_rx_fifo;

  localparam int BIT_CLK = 160;
  // Start edge driven just after clock edge 0: two synchronizer edges, one
  // edge into START, then 152 ticks of 10 clocks. The stop sample lands on
  // edge 1523, and the push updates the FIFO on edge 1524.
  localparam int STOP_SAMPLE_EDGE = 1523;

  logic       clk_clk;
  logic       reset_reset_n;
  logic       uart_rxd;
  logic       rx_fifo_read_export;
  logic [7:0] rx_char_export;
  logic       rx_fifo_empty_export;
  logic       rx_fifo_full;
  logic       rx_overflow;
  logic       rx_frame_err;
  logic       err_clr;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  tmc_uart_rx_fifo #(
    .CLK_HZ(1600000), .BAUD(10000), .OVERSAMPLE(16), .FIFO_DEPTH(16), .FIFO_AW(4)
  ) dut (
    .clk_clk(clk_clk),
    .reset_reset_n(reset_reset_n),
    .uart_rxd(uart_rxd),
    .rx_fifo_read_export(rx_fifo_read_export),
    .rx_char_export(rx_char_export),
    .rx_fifo_empty_export(rx_fifo_empty_export),
    .rx_fifo_full(rx_fifo_full),
    .rx_overflow(rx_overflow),
    .rx_frame_err(rx_frame_err),
    .err_clr(err_clr)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    uart_rxd = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      wait_clk(BIT_CLK);
    end
    if (stop_ok) begin
      uart_rxd = 1'b1;
      wait_clk(BIT_CLK);
    end else begin
      uart_rxd = 1'b0;
      wait_clk(2 * BIT_CLK);
      uart_rxd = 1'b1;
      wait_clk(BIT_CLK);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    if (exp_q.size() < 16) exp_q.push_back(b);
    send_frame(b, 1'b1);
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got 0x%0h, expected nothing (scoreboard empty)", tag, rx_char_export);
    end else begin
      check(tag, 32'(rx_char_export), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic do_read(input string tag);
    pop_check(tag);
    rx_fifo_read_export = 1'b1;
    wait_clk(2);
    rx_fifo_read_export = 1'b0;
    wait_clk(2);
  endtask

  initial begin
    #(10 * 80000);
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int n;
    logic [7:0] pb;
    reset_reset_n       = 1'b0;
    uart_rxd            = 1'b1;
    rx_fifo_read_export = 1'b0;
    err_clr             = 1'b0;
    wait_clk(5);
    check("rst_empty", 32'(rx_fifo_empty_export), 32'd1);
    check("rst_full", 32'(rx_fifo_full), 32'd0);
    check("rst_overflow", 32'(rx_overflow), 32'd0);
    check("rst_frame_err", 32'(rx_frame_err), 32'd0);
    check("rst_char", 32'(rx_char_export), 32'd0);
    reset_reset_n = 1'b1;
    wait_clk(5);

    // Single byte with start-edge-to-empty latency
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        n = 0;
        while (rx_fifo_empty_export === 1'b1 && n < 2000) begin
          @(posedge clk_clk);
          #1;
          n++;
        end
      end
    join
    $display("single byte: empty fell %0d clocks after start edge", n);
    check("latency_1520_1524", 32'(n >= 1520 && n <= 1524), 32'd1);
    check("a5_not_empty", 32'(rx_fifo_empty_export), 32'd0);
    pop_check("a5_char");
    rx_fifo_read_export = 1'b1;
    wait_clk(2);
    check("a5_empty_after_pop", 32'(rx_fifo_empty_export), 32'd1);
    rx_fifo_read_export = 1'b0;
    wait_clk(2);

    // False start followed by a good frame
    uart_rxd = 1'b0;
    wait_clk(50);
    uart_rxd = 1'b1;
    wait_clk(300);
    check("false_start_empty", 32'(rx_fifo_empty_export), 32'd1);
    send_byte(8'h3C);
    check("3c_not_empty", 32'(rx_fifo_empty_export), 32'd0);
    do_read("3c_char");
    check("3c_empty", 32'(rx_fifo_empty_export), 32'd1);

    // Framing error, break, then recovery
    send_frame(8'h55, 1'b0);
    check("ferr_set", 32'(rx_frame_err), 32'd1);
    check("ferr_no_push", 32'(rx_fifo_empty_export), 32'd1);
    send_byte(8'h81);
    send_byte(8'h42);
    check("ferr_sticky", 32'(rx_frame_err), 32'd1);
    check("81_head", 32'(rx_char_export), 32'(exp_q[0]));

    // Reset during data bit 4 with two bytes queued
    pb = 8'h0F;
    uart_rxd = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = pb[i];
      wait_clk(BIT_CLK);
    end
    uart_rxd = pb[4];
    wait_clk(BIT_CLK / 2);
    reset_reset_n = 1'b0;
    #1;
    check("midrst_empty", 32'(rx_fifo_empty_export), 32'd1);
    check("midrst_full", 32'(rx_fifo_full), 32'd0);
    check("midrst_overflow", 32'(rx_overflow), 32'd0);
    check("midrst_frame_err", 32'(rx_frame_err), 32'd0);
    exp_q.delete();
    uart_rxd = 1'b1;
    wait_clk(10);
    reset_reset_n = 1'b1;
    wait_clk(20);
    send_byte(8'hF0);
    do_read("f0_char");
    check("f0_empty", 32'(rx_fifo_empty_export), 32'd1);

    // Held read level pops exactly once
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    pop_check("held_head");
    rx_fifo_read_export = 1'b1;
    wait_clk(100);
    rx_fifo_read_export = 1'b0;
    wait_clk(2);
    check("held_not_empty", 32'(rx_fifo_empty_export), 32'd0);
    do_read("held_second");
    do_read("held_third");
    check("held_empty", 32'(rx_fifo_empty_export), 32'd1);

    // Fill to 16, overflow on the 17th
    for (int i = 0; i < 17; i++) begin
      send_byte(8'(i));
      if (i == 14) check("full_at_15", 32'(rx_fifo_full), 32'd0);
      if (i == 15) check("full_at_16", 32'(rx_fifo_full), 32'd1);
      if (i == 15) check("no_ovf_at_16", 32'(rx_overflow), 32'd0);
    end
    check("full_after_17", 32'(rx_fifo_full), 32'd1);
    check("ovf_after_17", 32'(rx_overflow), 32'd1);
    err_clr = 1'b1;
    wait_clk(1);
    err_clr = 1'b0;
    wait_clk(1);
    check("ovf_cleared", 32'(rx_overflow), 32'd0);

    // Pop coincident with a push while full
    pop_check("coinc_head");
    exp_q.push_back(8'hEE);
    fork
      send_frame(8'hEE, 1'b1);
      begin
        wait_clk(STOP_SAMPLE_EDGE);
        rx_fifo_read_export = 1'b1;
        wait_clk(3);
        rx_fifo_read_export = 1'b0;
      end
    join
    check("coinc_full", 32'(rx_fifo_full), 32'd1);
    check("coinc_no_ovf", 32'(rx_overflow), 32'd0);

    for (int k = 0; k < 16; k++) begin
      do_read($sformatf("drain_%0d", k));
    end
    check("drain_empty", 32'(rx_fifo_empty_export), 32'd1);
    check("drain_not_full", 32'(rx_fifo_full), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
